// File: rtl/axil_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | axil_arb_pkg : shared types, mode constants and width helper for the       |
// |                AXI-Lite write-channel arbiter.        Rev 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

package axil_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACKN = 1'b1
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // A single master still needs a 1-bit index port.
  function automatic int cdr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_arb_pick.sv
// +----------------------------------------------------------------------------+
// | axil_arb_pick : combinational request picker, fixed priority or rotating   |
// |                 search from rr_ptr.                  Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module axil_arb_pick
  import axil_arb_pkg::*;
#(
  parameter int NUMBER_MASTER = 4,
  parameter int CDR_W         = cdr_width(NUMBER_MASTER)
) (
  input  logic [NUMBER_MASTER-1:0] request,
  input  logic [CDR_W-1:0]         rr_ptr,
  input  logic                     mode,
  output logic [NUMBER_MASTER-1:0] grant,
  output logic [CDR_W-1:0]         grant_idx,
  output logic                     found
);

  always_comb begin
    logic [CDR_W-1:0] start;
    logic [CDR_W:0]   pos;
    logic [CDR_W-1:0] idx;

    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    start     = mode ? rr_ptr : '0;
    pos       = '0;
    idx       = '0;

    // Walk the masters starting at 'start', wrapping at NUMBER_MASTER.
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      pos = {1'b0, start} + (CDR_W+1)'(i);
      if (pos >= (CDR_W+1)'(NUMBER_MASTER)) begin
        pos = pos - (CDR_W+1)'(NUMBER_MASTER);
      end
      idx = pos[CDR_W-1:0];
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axil_arbiter_wr.sv
// +----------------------------------------------------------------------------+
// | axil_arbiter_wr : AXI-Lite write arbiter, grant held until B handshake.    |
// | Optional watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.   Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module axil_arbiter_wr
  import axil_arb_pkg::*;
#(
  parameter int NUMBER_MASTER  = 4,
  parameter int ARB_MODE       = ARB_FIXED,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [NUMBER_MASTER-1:0]             request_wr,
  output logic [NUMBER_MASTER-1:0]             grant_wr,
  output logic [cdr_width(NUMBER_MASTER)-1:0]  grant_wr_cdr,
  input  logic                                 s_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0]             m_axil_bready,
  output logic                                 busy,
  output logic                                 timeout_err
);

  localparam int CDR_W = cdr_width(NUMBER_MASTER);

  if (NUMBER_MASTER < 1 || NUMBER_MASTER > 16 || TIMEOUT_CYCLES < 2 ||
      (ARB_MODE != ARB_FIXED && ARB_MODE != ARB_RR)) begin : g_cfg_check
    $error("axil_arbiter_wr: illegal parameter combination");
  end

  arb_state_t               state_q, state_d;
  logic [NUMBER_MASTER-1:0] grant_q, grant_d;
  logic [CDR_W-1:0]         cdr_q, cdr_d;
  logic [CDR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CDR_W:0]           rr_next;

  logic [NUMBER_MASTER-1:0] pick_grant;
  logic [CDR_W-1:0]         pick_idx;
  logic                     pick_found;
  logic                     b_hs;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  axil_arb_pick #(
    .NUMBER_MASTER (NUMBER_MASTER),
    .CDR_W         (CDR_W)
  ) u_pick (
    .request   (request_wr),
    .rr_ptr    (rr_ptr_q),
    .mode      (ARB_MODE == ARB_RR),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .found     (pick_found)
  );

  assign b_hs = s_axil_bvalid && m_axil_bready[cdr_q];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cdr_d    = cdr_q;
    rr_ptr_d = rr_ptr_q;
    rr_next  = {1'b0, pick_idx} + (CDR_W+1)'(1);
`ifdef AXIL_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = ACKN;
          grant_d  = pick_grant;
          cdr_d    = pick_idx;
          rr_ptr_d = (rr_next == (CDR_W+1)'(NUMBER_MASTER)) ? '0 : rr_next[CDR_W-1:0];
`ifdef AXIL_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ACKN: begin
        // A handshake always takes precedence over the watchdog.
        if (b_hs) begin
          state_d = IDLE;
          grant_d = '0;
          cdr_d   = '0;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          grant_d   = '0;
          cdr_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cdr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      cdr_q    <= '0;
      rr_ptr_q <= '0;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cdr_q    <= cdr_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant_wr     = grant_q;
  assign grant_wr_cdr = cdr_q;
  assign busy         = (state_q == ACKN);

`ifdef AXIL_ARB_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire
